// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared constants, FSM state encoding and helpers for the multi-cycle signed
// multiply/divide controller.
// Ports: none (package).
// -----------------------------------------------------------------------------
package multdiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ITERS = 32;
   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MULT = 3'd1,
      ST_DIV  = 3'd2,
      ST_DFIX = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Two's-complement magnitude by local invert-plus-one (INT_MIN maps to itself,
   // which is the correct unsigned magnitude 2^31).
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      magnitude = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/multdiv_counter.sv
// -----------------------------------------------------------------------------
// multdiv_counter
// Iteration counter for the multiply/divide sequencer.
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous active-low reset
//   clr_i        - synchronous clear to zero (priority over enable)
//   en_i         - count enable
//   last_iter_o  - registered flag, high while count == ITERS-1
// -----------------------------------------------------------------------------
module multdiv_counter #(
   parameter int unsigned CNT_W = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic last_iter_o
);
   import multdiv_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;

   // Next count and look-ahead of the terminal flag so it can be registered.
   always_comb begin : cnt_next
      cnt_d  = cnt_q;
      last_d = last_q;
      if (clr_i) begin
         cnt_d  = '0;
         last_d = (LAST == '0);
      end else if (en_i) begin
         cnt_d  = cnt_q + CNT_W'(1);
         last_d = (cnt_d == LAST);
      end
   end

   always_ff @(posedge clock) begin : cnt_reg
      if (!reset) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign last_iter_o = last_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring, on
// magnitudes) controller. Drives a shared external 32-bit adder, one add per
// cycle, and reports a one-cycle result-ready pulse with an exception flag.
// Ports:
//   clock, reset            - clock and synchronous active-low reset
//   ctrl_MULT, ctrl_DIV     - start pulses (MULT wins when both high)
//   data_operandA/B         - multiplicand/dividend, multiplier/divisor
//   adder_a/b/cin           - external adder inputs (combinational from state)
//   adder_sum/cout          - external adder outputs
//   data_result             - product low word or quotient (held until next)
//   data_exception          - overflow / divide-by-zero, valid with RDY
//   data_resultRDY          - one-cycle pulse when data_result is final
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
   parameter int unsigned WIDTH = multdiv_pkg::WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] adder_a,
   output logic [WIDTH-1:0] adder_b,
   output logic             adder_cin,
   input  logic [WIDTH-1:0] adder_sum,
   input  logic             adder_cout,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   import multdiv_pkg::*;

   state_e state_q, state_d;

   // hi/lo double as R/Q during divide; m holds M (multiply) or |B| (divide).
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             q1_q, q1_d;
   logic             negq_q, negq_d;
   logic             is_div_q, is_div_d;
   logic             div_exc_q, div_exc_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic             start_c;
   logic             div_zero_c;
   logic             last_iter_c;
   logic             cnt_en_c;
   logic             booth_sign_c;
   logic [WIDTH-1:0] r_shift_c;

   assign start_c    = ctrl_MULT | ctrl_DIV;
   assign div_zero_c = (data_operandB == '0);
   assign cnt_en_c   = (state_q == ST_MULT) || (state_q == ST_DIV);
   assign r_shift_c  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

   // True 33-bit sign of hi +/- M; keeps the arithmetic shift correct when the
   // 32-bit add overflows (e.g. 0 - INT_MIN).
   assign booth_sign_c = adder_a[WIDTH-1] ^ adder_b[WIDTH-1] ^ adder_cout;

   multdiv_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clock       (clock),
      .reset       (reset),
      .clr_i       (start_c),
      .en_i        (cnt_en_c),
      .last_iter_o (last_iter_c)
   );

   // FSM state register.
   always_ff @(posedge clock) begin : fsm_reg
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; a start in any state overrides the sequence.
   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         ST_MULT: if (last_iter_c) state_d = ST_DONE;
         ST_DIV:  if (last_iter_c) state_d = ST_DFIX;
         ST_DFIX: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (ctrl_MULT)     state_d = ST_MULT;
      else if (ctrl_DIV) state_d = div_zero_c ? ST_DONE : ST_DIV;
   end

   // FSM outputs: external adder operands, zero outside active states.
   always_comb begin : fsm_out
      adder_a   = '0;
      adder_b   = '0;
      adder_cin = 1'b0;
      case (state_q)
         ST_MULT: begin
            adder_a = hi_q;
            case ({lo_q[0], q1_q})
               2'b01: adder_b = m_q;
               2'b10: begin
                  adder_b   = ~m_q;
                  adder_cin = 1'b1;
               end
               default: adder_b = '0;
            endcase
         end
         ST_DIV: begin
            adder_a   = r_shift_c;
            adder_b   = ~m_q;
            adder_cin = 1'b1;
         end
         ST_DFIX: begin
            if (negq_q) begin
               adder_a   = ~lo_q;
               adder_cin = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath next values: operand capture on start, one step per active cycle.
   always_comb begin : dp_next
      hi_d      = hi_q;
      lo_d      = lo_q;
      m_d       = m_q;
      q1_d      = q1_q;
      negq_d    = negq_q;
      is_div_d  = is_div_q;
      div_exc_d = div_exc_q;
      if (ctrl_MULT) begin
         hi_d      = '0;
         lo_d      = data_operandB;
         m_d       = data_operandA;
         q1_d      = 1'b0;
         negq_d    = 1'b0;
         is_div_d  = 1'b0;
         div_exc_d = 1'b0;
      end else if (ctrl_DIV) begin
         hi_d      = '0;
         lo_d      = div_zero_c ? '0 : magnitude(data_operandA);
         m_d       = magnitude(data_operandB);
         q1_d      = 1'b0;
         negq_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         is_div_d  = 1'b1;
         div_exc_d = div_zero_c ||
                     ((data_operandA == INT_MIN) && (data_operandB == '1));
      end else begin
         case (state_q)
            ST_MULT: begin
               hi_d = {booth_sign_c, adder_sum[WIDTH-1:1]};
               lo_d = {adder_sum[0], lo_q[WIDTH-1:1]};
               q1_d = lo_q[0];
            end
            ST_DIV: begin
               // Carry-out of R + ~|B| + 1 means R >= |B|: keep the difference.
               if (adder_cout) begin
                  hi_d = adder_sum;
                  lo_d = {lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  hi_d = r_shift_c;
                  lo_d = {lo_q[WIDTH-2:0], 1'b0};
               end
            end
            ST_DFIX: if (negq_q) lo_d = adder_sum;
            default: ;
         endcase
      end
   end

   // Result handshake; an abort landing on DONE suppresses the pulse.
   always_comb begin : res_next
      rdy_d    = (state_q == ST_DONE) && !start_c;
      result_d = rdy_d ? lo_q : result_q;
      exc_d    = 1'b0;
      if (rdy_d) begin
         exc_d = is_div_q ? div_exc_q : (hi_q != {WIDTH{lo_q[WIDTH-1]}});
      end
   end

   always_ff @(posedge clock) begin : dp_reg
      if (!reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         m_q       <= '0;
         q1_q      <= 1'b0;
         negq_q    <= 1'b0;
         is_div_q  <= 1'b0;
         div_exc_q <= 1'b0;
         result_q  <= '0;
         exc_q     <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         m_q       <= m_d;
         q1_q      <= q1_d;
         negq_q    <= negq_d;
         is_div_q  <= is_div_d;
         div_exc_q <= div_exc_d;
         result_q  <= result_d;
         exc_q     <= exc_d;
         rdy_q     <= rdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Multi-cycle signed multiply/divide controller for the processor's execute stage.
- Owns the operand, product and remainder registers and the iteration counter. Drives a single external 32-bit carry-lookahead adder, the same adder instance the ALU uses, one operation per cycle.
- Implements radix-2 Booth multiplication and restoring division on magnitudes.
- Reports result-ready and an exception flag back to the pipeline stall logic.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the adder is fixed at 32 bits.
- CNT_W, 6, iteration counter width. Must hold WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock
- ctrl_MULT  input  1  one-cycle pulse; start a multiply with the current operands
- ctrl_DIV  input  1  one-cycle pulse; start a divide with the current operands
- data_operandA  input  32  multiplicand / dividend (two's complement)
- data_operandB  input  32  multiplier / divisor (two's complement)
- adder_a  output  32  external adder operand A
- adder_b  output  32  external adder operand B
- adder_cin  output  1  external adder carry-in
- adder_sum  input  32  external adder sum, combinational from adder_a/b/cin
- adder_cout  input  1  external adder carry-out (c32)
- data_result  output  32  product low word or quotient
- data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY=1
- data_resultRDY  output  1  one-cycle pulse when data_result is final

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; all registers and the counter cleared.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - adder_a/adder_b/adder_cin=0.
  - Reset mid-operation discards the operation; no RDY pulse is produced.
- States: IDLE, MULT, DIV, DFIX, DONE.
- Start:
  - In any state, ctrl_MULT or ctrl_DIV at an edge samples the operands, clears the counter and enters MULT or DIV.
  - If both are high, MULT wins.
  - A start while busy aborts the current operation; no RDY is produced for it.
- MULT (signed Booth):
  - Registers: hi (32), lo = operandB, q_1 = 0, M = operandA.
  - Each cycle, on {lo[0], q_1}:
    - 01: adder_a=hi, adder_b=M, cin=0.
    - 10: adder_a=hi, adder_b=~M, cin=1.
    - 00/11: adder_a=hi, adder_b=0, cin=0.
  - Then {hi, lo, q_1} <= arithmetic shift right by 1 of {adder_sum, lo, q_1}.
  - 32 iterations (counter 0..31), then DONE.
- DIV (restoring, on magnitudes):
  - At start: |A| and |B| are formed by local invert-plus-one (not via the adder); negq = A[31]^B[31].
  - Q=|A|, R=0.
  - Each iteration: {R, Q} shift left by 1. Drive adder_a=R, adder_b=~|B|, cin=1.
    - If adder_cout=1: R<=adder_sum, Q[0]<=1.
    - Else R unchanged, Q[0]<=0.
  - 32 iterations, then DFIX.
- DFIX (one cycle):
  - If negq: adder_a=~Q, adder_b=0, cin=1; Q<=adder_sum.
  - Else Q unchanged. Then DONE.
- Divide by zero:
  - operandB==0 with ctrl_DIV goes directly to DONE.
  - result=0, exception=1.
- DONE (one cycle):
  - data_resultRDY=1.
  - data_result = lo (MULT) or Q (DIV).
  - MULT exception: hi is not all-equal to lo[31].
  - DIV exception: operandB==0, or operandA==0x80000000 with operandB==0xFFFFFFFF (result 0x80000000).
  - Next state IDLE.
- data_result holds its value after DONE until the next DONE or reset. data_exception clears with RDY.
- Latency, with the start edge as cycle 0:
  - MULT: RDY high in cycle 33.
  - DIV: RDY high in cycle 34.
  - Divide-by-zero: RDY high in cycle 1.
- In IDLE and DONE the adder inputs are driven to 0.

Decomposition:
- Shared package/include holds:
  - state encoding (IDLE=0, MULT=1, DIV=2, DFIX=3, DONE=4);
  - WIDTH=32;
  - ITERS=32;
  - INT_MIN=32'h80000000.
- One sub-module: multdiv_counter. It is a CNT_W-bit counter with synchronous active-low reset, synchronous clear and enable, and an output last_iter for count==ITERS-1.

Test Plan:
- MULT A=7, B=-3 (0xFFFFFFFD) -> RDY only in cycle 33, result 0xFFFFFFEB, exception 0. Confirm adder_cin=1 on subtract cycles.
- MULT A=0x00010000, B=0x00010000 -> cycle 33 result 0x00000000, exception 1. Then MULT 0x80000000*1 -> result 0x80000000, exception 0.
- DIV A=-100 (0xFFFFFF9C), B=7 -> RDY only in cycle 34, result 0xFFFFFFF2 (-14), exception 0. Then DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
- DIV A=5, B=0 -> RDY in cycle 1, result 0, exception 1. No adder activity (inputs 0).
- Restart: MULT 3*4 at cycle 0, then DIV 100/10 at cycle 10 -> no RDY at cycle 33. RDY at cycle 44 with result 10 (0x0000000A).
- Reset: MULT 6*6, reset=0 at cycle 15 -> from cycle 16 RDY=0, result=0, adder inputs 0. After release, MULT 6*6 gives RDY 33 cycles later with result 36 (0x24).
